// File: rtl/l1_refill_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l1_refill_pkg
// Brief    : Shared types and helpers for the L1 refill controller.
// Revision : 1.0
// ============================================================================
package l1_refill_pkg;

    localparam int BEAT_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Line base with the byte offset cleared, beat index placed above the 8-byte lane.
    function automatic logic [63:0] beat_addr(
        input logic [63:0] line_addr,
        input int unsigned off_bits,
        input logic [63:0] beat_idx
    );
        logic [63:0] w_mask;
        w_mask = ~((64'd1 << off_bits) - 64'd1);
        return (line_addr & w_mask) | (beat_idx << $clog2(BEAT_BYTES));
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_rd_tracker.sv
`default_nettype none
// ============================================================================
// Module   : l2_rd_tracker
// Brief    : Tracks in-flight L2 reads and registers the returning refill beats.
// Revision : 1.0
// ============================================================================
module l2_rd_tracker #(
    parameter  int BEATS  = 8,
    parameter  int RD_LAT = 1,
    localparam int IDX_W  = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    input  logic [63:0]      rdata_i,
    output logic             refill_valid_o,
    output logic [IDX_W-1:0] refill_idx_o,
    output logic [63:0]      refill_data_o,
    output logic             empty_o,
    output logic             wrapped_o
);

    logic [RD_LAT-1:0] r_inflight;
    logic [IDX_W-1:0]  r_ret_cnt;
    logic              w_ret;

    // The oldest stage is set exactly in the cycle its data sits on rdata_i.
    assign w_ret = r_inflight[RD_LAT-1];

    generate
        if (RD_LAT == 1) begin : g_lat_one
            always_ff @(posedge clk) begin
                if (rst) r_inflight <= '0;
                else     r_inflight <= issue_i;
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk) begin
                if (rst) r_inflight <= '0;
                else     r_inflight <= {r_inflight[RD_LAT-2:0], issue_i};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ret_cnt      <= '0;
            refill_valid_o <= 1'b0;
            refill_idx_o   <= '0;
            refill_data_o  <= '0;
        end else begin
            refill_valid_o <= w_ret;
            if (w_ret) begin
                refill_idx_o  <= r_ret_cnt;
                refill_data_o <= rdata_i;
                r_ret_cnt     <= r_ret_cnt + IDX_W'(1);
            end
        end
    end

    assign empty_o   = ~|r_inflight;
    assign wrapped_o = (r_ret_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/l1_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : l1_refill_ctrl
// Brief    : L1 miss handler: optional victim writeback, then pipelined line refill from L2.
// Revision : 1.0
// ============================================================================
module l1_refill_ctrl
    import l1_refill_pkg::*;
#(
    parameter  int LINE_BYTES = 64,
    parameter  int RD_LAT     = 1,
    localparam int BEATS      = LINE_BYTES / BEAT_BYTES,
    localparam int IDX_W      = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_valid_i,
    input  logic [63:0]      miss_addr_i,
    input  logic             miss_dirty_i,
    input  logic [63:0]      victim_addr_i,
    output logic             miss_ready_o,
    output logic [IDX_W-1:0] victim_idx_o,
    input  logic [63:0]      victim_rdata_i,
    output logic             l2_req_valid_o,
    output logic [63:0]      l2_req_addr_o,
    output logic             l2_req_write_o,
    output logic [63:0]      l2_req_wdata_o,
    input  logic             l2_req_ready_i,
    input  logic [63:0]      l2_rdata_i,
    output logic             refill_valid_o,
    output logic [IDX_W-1:0] refill_idx_o,
    output logic [63:0]      refill_data_o,
    output logic             refill_done_o
);

    localparam int unsigned      c_off_bits  = $clog2(LINE_BYTES);
    localparam logic [IDX_W-1:0] c_last_beat = IDX_W'(BEATS - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [63:0]      r_miss_addr;
    logic [63:0]      r_victim_addr;
    logic [IDX_W-1:0] r_wr_cnt;
    logic [IDX_W-1:0] r_rd_cnt;
    logic             w_accept;
    logic             w_rd_issue;
    logic             w_trk_empty;
    logic             w_trk_wrapped;

    assign w_accept     = l2_req_valid_o & l2_req_ready_i;
    assign w_rd_issue   = w_accept & ~l2_req_write_o;
    assign victim_idx_o = r_wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_miss_addr   <= '0;
            r_victim_addr <= '0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && miss_valid_i) begin
                r_miss_addr   <= miss_addr_i;
                r_victim_addr <= victim_addr_i;
            end
            // Both counters wrap back to zero on their last beat, ready for the next miss.
            if (r_state == WB && w_accept) r_wr_cnt <= r_wr_cnt + IDX_W'(1);
            if (r_state == RD && w_accept) r_rd_cnt <= r_rd_cnt + IDX_W'(1);
        end
    end

    // Request fields depend only on state and counters, so they hold while L2 stalls.
    always_comb begin
        w_state_nxt    = r_state;
        miss_ready_o   = 1'b0;
        l2_req_valid_o = 1'b0;
        l2_req_write_o = 1'b0;
        l2_req_addr_o  = '0;
        l2_req_wdata_o = '0;
        refill_done_o  = 1'b0;
        case (r_state)
            IDLE: begin
                miss_ready_o = 1'b1;
                if (miss_valid_i) w_state_nxt = miss_dirty_i ? WB : RD;
            end
            WB: begin
                l2_req_valid_o = 1'b1;
                l2_req_write_o = 1'b1;
                l2_req_addr_o  = beat_addr(r_victim_addr, c_off_bits, 64'(r_wr_cnt));
                l2_req_wdata_o = victim_rdata_i;
                if (l2_req_ready_i && r_wr_cnt == c_last_beat) w_state_nxt = RD;
            end
            RD: begin
                l2_req_valid_o = 1'b1;
                l2_req_addr_o  = beat_addr(r_miss_addr, c_off_bits, 64'(r_rd_cnt));
                if (l2_req_ready_i && r_rd_cnt == c_last_beat) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_trk_empty && w_trk_wrapped) w_state_nxt = DONE;
            end
            DONE: begin
                refill_done_o = 1'b1;
                w_state_nxt   = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    l2_rd_tracker #(
        .BEATS  (BEATS),
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk            (clk),
        .rst            (rst),
        .issue_i        (w_rd_issue),
        .rdata_i        (l2_rdata_i),
        .refill_valid_o (refill_valid_o),
        .refill_idx_o   (refill_idx_o),
        .refill_data_o  (refill_data_o),
        .empty_o        (w_trk_empty),
        .wrapped_o      (w_trk_wrapped)
    );

endmodule
`default_nettype wire
